// File: rtl/div_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_ctrl                                                      |
// | Purpose  : Sequences one iterative Div instance for the EX stage.        |
// |            Accepts DIV/DIVU requests on a valid/ready handshake, resolves|
// |            divide-by-zero and signed overflow without the divider, and   |
// |            returns quotient/remainder on a valid/ready response port.    |
// |            An in-flight or pending operation can be killed with flush.   |
// | Option   : DIV_CTRL_MATCH_EN - when defined, a request whose operands    |
// |            match the divider's last completed operation reuses that      |
// |            result without restarting the divider.                        |
// | Ports    : clock, reset_n (sync, active-low), flush                      |
// |            req_valid/req_ready/req_op/req_dividend/req_divisor  request  |
// |            resp_valid/resp_ready/resp_q/resp_r                  response |
// |            div_op/div_start/div_dividend/div_divisor           to Div    |
// |            div_done/div_match/div_q/div_r                      from Div  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

package div;
  typedef enum logic {
    DIV  = 1'b0,  // signed
    DIVU = 1'b1   // unsigned
  } op_t;
endpackage

module div_ctrl #(
  parameter int DIVLEN = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  div::op_t          req_op,
  input  logic [DIVLEN-1:0] req_dividend,
  input  logic [DIVLEN-1:0] req_divisor,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DIVLEN-1:0] resp_q,
  output logic [DIVLEN-1:0] resp_r,
  output div::op_t          div_op,
  output logic              div_start,
  output logic [DIVLEN-1:0] div_dividend,
  output logic [DIVLEN-1:0] div_divisor,
  input  logic              div_done,
  input  logic              div_match,
  input  logic [DIVLEN-1:0] div_q,
  input  logic [DIVLEN-1:0] div_r
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [DIVLEN-1:0] C_ALL_ONES = {DIVLEN{1'b1}};
  localparam logic [DIVLEN-1:0] C_MIN_NEG  = {1'b1, {(DIVLEN-1){1'b0}}};

  state_t            state_q, state_d;
  div::op_t          op_q, op_d;
  logic [DIVLEN-1:0] dvd_q, dvd_d;
  logic [DIVLEN-1:0] dvs_q, dvs_d;
  logic [DIVLEN-1:0] res_q_q, res_q_d;
  logic [DIVLEN-1:0] res_r_q, res_r_d;
  logic              primed_q, primed_d;
  // High during the first BUSY cycle: Div has not stepped yet, so its
  // done flag may still reflect the previous operation.
  logic              busy_first_q;

  logic accept;
  logic divisor_zero;
  logic signed_ovf;
  logic match_hit;

  assign divisor_zero = (req_divisor == '0);
  assign signed_ovf   = (req_op == div::DIV) && (req_dividend == C_MIN_NEG) &&
                        (req_divisor == C_ALL_ONES);

`ifdef DIV_CTRL_MATCH_EN
  // Div outputs are unknown until it has been started once, hence primed.
  assign match_hit = primed_q && div_done && div_match;
`else
  logic unused_match;
  assign unused_match = div_match;
  assign match_hit    = 1'b0;
`endif

  // In IDLE the divider sees the live request so div_match compares against
  // it; afterwards it sees the latched copy.
  assign div_op       = (state_q == S_IDLE) ? req_op       : op_q;
  assign div_dividend = (state_q == S_IDLE) ? req_dividend : dvd_q;
  assign div_divisor  = (state_q == S_IDLE) ? req_divisor  : dvs_q;

  assign resp_q = res_q_q;
  assign resp_r = res_r_q;
  assign accept = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    res_q_d    = res_q_q;
    res_r_d    = res_r_q;
    primed_d   = primed_q;
    req_ready  = 1'b0;
    div_start  = 1'b0;
    resp_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = !flush;
        if (accept) begin
          op_d  = req_op;
          dvd_d = req_dividend;
          dvs_d = req_divisor;
          if (divisor_zero) begin
            res_q_d = C_ALL_ONES;
            res_r_d = req_dividend;
            state_d = S_RESP;
          end else if (signed_ovf) begin
            res_q_d = req_dividend;
            res_r_d = '0;
            state_d = S_RESP;
          end else if (match_hit) begin
            res_q_d = div_q;
            res_r_d = div_r;
            state_d = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        div_start = 1'b1;
        primed_d  = 1'b1;
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        if (!busy_first_q && div_done) begin
          res_q_d = div_q;
          res_r_d = div_r;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides every transition, including completion and hand-off.
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= div::DIV;
      dvd_q        <= '0;
      dvs_q        <= '0;
      res_q_q      <= '0;
      res_r_q      <= '0;
      primed_q     <= 1'b0;
      busy_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      res_q_q      <= res_q_d;
      res_r_q      <= res_r_d;
      primed_q     <= primed_d;
      busy_first_q <= (state_q == S_START);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_div_ctrl                                                   |
// | Purpose  : Self-checking bench for div_ctrl with a behavioural Div model |
// |            and a response scoreboard.                                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_div_ctrl;

  localparam int DIVLEN  = 32;
  localparam int LAT_DIV = DIVLEN + 3;
`ifdef DIV_CTRL_MATCH_EN
  localparam int MATCH_LAT = 1;
  localparam int MATCH_NST = 0;
`else
  localparam int MATCH_LAT = LAT_DIV;
  localparam int MATCH_NST = 1;
`endif

  logic              clock = 1'b0;
  logic              reset_n, flush, req_valid, req_ready;
  logic              resp_valid, resp_ready, div_start, div_done, div_match;
  div::op_t          req_op, div_op;
  logic [DIVLEN-1:0] req_dividend, req_divisor, resp_q, resp_r;
  logic [DIVLEN-1:0] div_dividend, div_divisor, div_q, div_r;

  always #5 clock = ~clock;

  div_ctrl #(.DIVLEN(DIVLEN)) u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_q       (resp_q),
    .resp_r       (resp_r),
    .div_op       (div_op),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_done     (div_done),
    .div_match    (div_match),
    .div_q        (div_q),
    .div_r        (div_r)
  );

  // Div model: no reset; done stays at its old value during the cycle after
  // start, then drops and rises again DIVLEN+1 cycles after the start cycle.
  div::op_t          m_op;
  logic [DIVLEN-1:0] m_a, m_b;
  logic              m_arm = 1'b0;
  int                m_cnt = 0;

  always @(posedge clock) begin
    if (div_start) begin
      m_arm <= 1'b1;
      m_op  <= div_op;
      m_a   <= div_dividend;
      m_b   <= div_divisor;
    end else if (m_arm) begin
      m_arm    <= 1'b0;
      div_done <= 1'b0;
      m_cnt    <= DIVLEN - 2;
    end else if (div_done === 1'b0) begin
      if (m_cnt == 0) begin
        div_done <= 1'b1;
        if (m_op == div::DIVU) begin
          div_q <= m_a / m_b;
          div_r <= m_a % m_b;
        end else begin
          div_q <= $signed(m_a) / $signed(m_b);
          div_r <= $signed(m_a) % $signed(m_b);
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign div_match = (m_op == div_op) && (m_a == div_dividend) && (m_b == div_divisor);

  // Checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [DIVLEN-1:0] q;
    logic [DIVLEN-1:0] r;
    int                t;    // accept cycle
    int                lat;  // cycles until resp_valid
    int                nst;  // div_start pulses expected
    int                st0;  // start count at accept
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_starts = 0;
  int   last_start = 0;
  int   n_valid = 0;
  int   first_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (div_start === 1'b1) begin
      n_starts++;
      last_start = cyc;
    end
    if (resp_valid === 1'b1) n_valid++;
    if (resp_valid === 1'b1 && !prev_valid) first_cyc = cyc;
    prev_valid = (resp_valid === 1'b1);
    if (resp_valid === 1'b1 && resp_ready) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_q", resp_q, mon_e.q);
        chk("resp_r", resp_r, mon_e.r);
        chk("resp_latency", first_cyc - mon_e.t, mon_e.lat);
        chk("start_count", n_starts - mon_e.st0, mon_e.nst);
        if (mon_e.nst == 1) chk("start_cycle", last_start - mon_e.t, 1);
      end
    end
  end

  // Presents one request; returns #1 after the accepting edge.
  task automatic do_req(input div::op_t op, input logic [DIVLEN-1:0] a, input logic [DIVLEN-1:0] b,
                        input logic push_it, input logic [DIVLEN-1:0] eq, input logic [DIVLEN-1:0] er,
                        input int lat, input int nst);
    exp_t e;
    @(posedge clock); #1;
    req_valid    = 1'b1;
    req_op       = op;
    req_dividend = a;
    req_divisor  = b;
    @(negedge clock);
    chk("req_ready", req_ready, 1);
    if (push_it) begin
      e.q = eq; e.r = er; e.t = cyc; e.lat = lat; e.nst = nst; e.st0 = n_starts;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 200) begin
      @(posedge clock);
      i++;
    end
    chk("resp_timeout", sb.size(), 0);
    #1;
  endtask

  task automatic quiet(input int n, input string tag);
    int v0;
    v0 = n_valid;
    repeat (n) @(posedge clock);
    #1;
    chk(tag, n_valid - v0, 0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_op = div::DIVU; req_dividend = '0; req_divisor = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_q", resp_q, 0);
    chk("rst_resp_r", resp_r, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_div_start", div_start, 0);

    // Divider path, unsigned and signed
    do_req(div::DIVU, 100, 7, 1, 14, 2, LAT_DIV, 1);                              wait_resp();
    do_req(div::DIV, 32'hFFFFFFF9, 2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, LAT_DIV, 1); wait_resp();
    do_req(div::DIV, 7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 1, LAT_DIV, 1);            wait_resp();

    // Divide-by-zero with backpressure
    resp_ready = 1'b0;
    do_req(div::DIVU, 32'h1234, 0, 1, 32'hFFFFFFFF, 32'h1234, 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid", resp_valid, 1);
      chk("bp_q", resp_q, 32'hFFFFFFFF);
      chk("bp_r", resp_r, 32'h1234);
      chk("bp_req_ready", req_ready, 0);
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_idle_valid", resp_valid, 0);

    // Remaining corner cases
    do_req(div::DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 0, 1, 0);       wait_resp();
    do_req(div::DIV, 32'h80000000, 0, 1, 32'hFFFFFFFF, 32'h80000000, 1, 0);       wait_resp();
    do_req(div::DIVU, 32'h80000000, 32'hFFFFFFFF, 1, 0, 32'h80000000, LAT_DIV, 1); wait_resp();

    // Back-to-back identical operands
    do_req(div::DIVU, 100, 7, 1, 14, 2, LAT_DIV, 1);       wait_resp();
    do_req(div::DIVU, 100, 7, 1, 14, 2, MATCH_LAT, MATCH_NST); wait_resp();

    // Flush while busy
    do_req(div::DIVU, 100, 7, 0, 0, 0, 0, 0);
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    chk("flush_valid", resp_valid, 0);
    chk("flush_idle", req_ready, 1);
    quiet(45, "flush_no_resp");

    // Flush with a request in IDLE
    @(posedge clock); #1;
    flush = 1'b1; req_valid = 1'b1; req_op = div::DIVU; req_dividend = 50; req_divisor = 5;
    @(negedge clock);
    chk("flush_req_ready", req_ready, 0);
    @(posedge clock); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    chk("flush_not_accepted", req_ready, 1);
    chk("flush_no_start", div_start, 0);
    quiet(45, "flush_idle_no_resp");

    // Reset mid-operation, then the same operands must not reuse a result
    do_req(div::DIVU, 1000, 3, 0, 0, 0, 0, 0);
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst2_valid", resp_valid, 0);
    chk("rst2_q", resp_q, 0);
    chk("rst2_r", resp_r, 0);
    chk("rst2_ready", req_ready, 1);
    quiet(45, "rst_no_resp");
    do_req(div::DIVU, 1000, 3, 1, 333, 1, LAT_DIV, 1); wait_resp();

    repeat (3) @(posedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
